store_buffer: RTL and testbench

- Circular FIFO of pending stores between the LSU and data memory, directly downstream of the ROB's store-buffer retire ports.
- At dispatch the decoder allocates up to 2 entries per cycle. The LSU fills each entry with its address and data. The ROB commits up to 2 entries per cycle at retire.
- Committed entries drain in order to data memory, one per cycle.
- Younger loads get store-to-load forwarding from filled entries.

---
 rtl/sb_pkg.sv | 20 ++
 rtl/sb_fwd_select.sv | 30 +++
 rtl/store_buffer.sv | 113 +++++++++++
 tb/tb_store_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared sizing and entry layout for the store buffer and its forwarding scan.
package sb_pkg;

  localparam int SB_DEPTH = 32;
  localparam int SB_SIZE  = 5;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;

  typedef logic [SB_SIZE-1:0] sb_idx_t;
  typedef logic [SB_SIZE:0]   sb_cnt_t;

  typedef struct packed {
    logic              busy;
    logic              filled;
    logic              committed;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_select.sv
// Store-to-load forwarding: youngest busy, filled entry whose address matches the load.
module sb_fwd_select
  import sb_pkg::*;
(
  input  sb_entry_t         entries [SB_DEPTH],
  input  sb_idx_t           head,
  input  sb_cnt_t           count,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  sb_idx_t idx;

  // Walk oldest to youngest so a later (younger) match overwrites an older one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head + k[SB_SIZE-1:0];
      if ((sb_cnt_t'(k) < count) && entries[idx].busy && entries[idx].filled &&
          (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular buffer of pending stores: dual allocate, LSU fill, dual commit,
// in-order single drain to memory, flush of uncommitted entries, load forwarding.
module store_buffer
  import sb_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              Flush,
  input  logic              Alloc1_V,
  input  logic              Alloc2_V,
  output logic [SB_SIZE-1:0] Alloc_Idx1,
  output logic [SB_SIZE-1:0] Alloc_Idx2,
  output logic              SB_stall,
  input  logic              LSU_St_V,
  input  logic [SB_SIZE-1:0] LSU_St_Idx,
  input  logic [ADDR_W-1:0] LSU_St_Addr,
  input  logic [DATA_W-1:0] LSU_St_Data,
  input  logic              ROB_Retire1_SB_V,
  input  logic [SB_SIZE-1:0] ROB_Retire1_SB_Addr,
  input  logic              ROB_Retire2_SB_V,
  input  logic [SB_SIZE-1:0] ROB_Retire2_SB_Addr,
  input  logic              Mem_Ready,
  output logic              Mem_Wr_En,
  output logic [ADDR_W-1:0] Mem_Wr_Addr,
  output logic [DATA_W-1:0] Mem_Wr_Data,
  input  logic [ADDR_W-1:0] Ld_Addr,
  output logic              Ld_Fwd_Hit,
  output logic [DATA_W-1:0] Ld_Fwd_Data
);

  localparam sb_entry_t FRESH = '{busy: 1'b1, filled: 1'b0, committed: 1'b0,
                                  addr: '0, data: '0};

  sb_entry_t sb_q [SB_DEPTH];
  sb_entry_t sb_d [SB_DEPTH];
  sb_idx_t   head_q, head_d, tail_q, tail_d;
  sb_cnt_t   count_q, count_d, n_alloc, n_keep;
  logic      drain;

  assign SB_stall    = (sb_cnt_t'(SB_DEPTH) - count_q) < sb_cnt_t'(2);
  assign Alloc_Idx1  = tail_q;
  assign Alloc_Idx2  = (Alloc2_V && !Alloc1_V) ? tail_q : tail_q + sb_idx_t'(1);
  assign Mem_Wr_En   = sb_q[head_q].busy & sb_q[head_q].filled & sb_q[head_q].committed;
  assign Mem_Wr_Addr = sb_q[head_q].addr;
  assign Mem_Wr_Data = sb_q[head_q].data;
  assign drain       = Mem_Wr_En & Mem_Ready;
  assign n_alloc     = SB_stall ? '0 : sb_cnt_t'(Alloc1_V) + sb_cnt_t'(Alloc2_V);

  // Same-cycle events are layered commit, fill, drain, then alloc or flush.
  always_comb begin
    sb_d    = sb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    n_keep  = '0;
    if (ROB_Retire1_SB_V && sb_q[ROB_Retire1_SB_Addr].busy)
      sb_d[ROB_Retire1_SB_Addr].committed = 1'b1;
    if (ROB_Retire2_SB_V && sb_q[ROB_Retire2_SB_Addr].busy)
      sb_d[ROB_Retire2_SB_Addr].committed = 1'b1;
    if (LSU_St_V) begin
      sb_d[LSU_St_Idx].filled = 1'b1;
      sb_d[LSU_St_Idx].addr   = LSU_St_Addr;
      sb_d[LSU_St_Idx].data   = LSU_St_Data;
    end
    if (drain) begin
      sb_d[head_q] = '0;
      head_d       = head_q + sb_idx_t'(1);
    end
    if (Flush) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (sb_d[i].busy && !sb_d[i].committed) sb_d[i] = '0;
        else if (sb_d[i].busy) n_keep = n_keep + sb_cnt_t'(1);
      end
      tail_d  = head_d + n_keep[SB_SIZE-1:0];
      count_d = n_keep;
    end else begin
      if (!SB_stall && Alloc1_V) sb_d[tail_q]     = FRESH;
      if (!SB_stall && Alloc2_V) sb_d[Alloc_Idx2] = FRESH;
      tail_d  = tail_q + n_alloc[SB_SIZE-1:0];
      count_d = count_q + n_alloc - sb_cnt_t'(drain);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      sb_q    <= sb_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  sb_fwd_select u_fwd (
    .entries (sb_q),
    .head    (head_q),
    .count   (count_q),
    .ld_addr (Ld_Addr),
    .hit     (Ld_Fwd_Hit),
    .data    (Ld_Fwd_Data)
  );

  // Committing an entry that was never allocated is a ROB protocol error.
  a_retire1_busy: assert property (@(posedge CLK) disable iff (RST)
    ROB_Retire1_SB_V |-> sb_q[ROB_Retire1_SB_Addr].busy);
  a_retire2_busy: assert property (@(posedge CLK) disable iff (RST)
    ROB_Retire2_SB_V |-> sb_q[ROB_Retire2_SB_Addr].busy);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue-based reference model checked every cycle,
// literal expectations per scenario, and an expected-write scoreboard.
module tb_store_buffer;

  localparam int DEPTH = 32;

  logic        CLK = 1'b0;
  logic        RST, Flush, Alloc1_V, Alloc2_V;
  logic [4:0]  Alloc_Idx1, Alloc_Idx2;
  logic        SB_stall;
  logic        LSU_St_V;
  logic [4:0]  LSU_St_Idx;
  logic [15:0] LSU_St_Addr, LSU_St_Data;
  logic        ROB_Retire1_SB_V, ROB_Retire2_SB_V;
  logic [4:0]  ROB_Retire1_SB_Addr, ROB_Retire2_SB_Addr;
  logic        Mem_Ready, Mem_Wr_En;
  logic [15:0] Mem_Wr_Addr, Mem_Wr_Data, Ld_Addr, Ld_Fwd_Data;
  logic        Ld_Fwd_Hit;

  store_buffer dut (
    .CLK(CLK), .RST(RST), .Flush(Flush),
    .Alloc1_V(Alloc1_V), .Alloc2_V(Alloc2_V),
    .Alloc_Idx1(Alloc_Idx1), .Alloc_Idx2(Alloc_Idx2), .SB_stall(SB_stall),
    .LSU_St_V(LSU_St_V), .LSU_St_Idx(LSU_St_Idx),
    .LSU_St_Addr(LSU_St_Addr), .LSU_St_Data(LSU_St_Data),
    .ROB_Retire1_SB_V(ROB_Retire1_SB_V), .ROB_Retire1_SB_Addr(ROB_Retire1_SB_Addr),
    .ROB_Retire2_SB_V(ROB_Retire2_SB_V), .ROB_Retire2_SB_Addr(ROB_Retire2_SB_Addr),
    .Mem_Ready(Mem_Ready), .Mem_Wr_En(Mem_Wr_En),
    .Mem_Wr_Addr(Mem_Wr_Addr), .Mem_Wr_Data(Mem_Wr_Data),
    .Ld_Addr(Ld_Addr), .Ld_Fwd_Hit(Ld_Fwd_Hit), .Ld_Fwd_Data(Ld_Fwd_Data)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          idx;
    bit          filled;
    bit          committed;
    logic [15:0] addr;
    logic [15:0] data;
  } m_ent_t;

  m_ent_t      mq[$];     // pending stores, oldest first
  m_ent_t      nq[$];
  int          m_head;
  logic [31:0] exp_q[$];  // {addr,data} of memory writes the scenarios expect

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic m_ent_t mk(input int idx);
    m_ent_t e;
    e.idx = idx; e.filled = 0; e.committed = 0; e.addr = '0; e.data = '0;
    return e;
  endfunction

  // ---------------- model + compare (negedge; inputs already hold next-edge values) ----
  always @(negedge CLK) begin : cmp
    int sz, tl, e2;
    bit e_en, e_hit, stl, drn;
    logic [15:0] e_fd;
    if (RST) begin
      mq.delete();
      m_head = 0;
    end else begin
      sz  = mq.size();
      tl  = (m_head + sz) % DEPTH;
      stl = (DEPTH - sz) < 2;
      e2  = (Alloc2_V && !Alloc1_V) ? tl : (tl + 1) % DEPTH;
      chk("alloc_idx1", 32'(Alloc_Idx1), 32'(tl));
      chk("alloc_idx2", 32'(Alloc_Idx2), 32'(e2));
      chk("sb_stall", 32'(SB_stall), 32'(stl));
      e_en = (sz > 0) && mq[0].filled && mq[0].committed;
      chk("mem_wr_en", 32'(Mem_Wr_En), 32'(e_en));
      if (e_en) begin
        chk("mem_wr_addr", 32'(Mem_Wr_Addr), 32'(mq[0].addr));
        chk("mem_wr_data", 32'(Mem_Wr_Data), 32'(mq[0].data));
      end
      e_hit = 0;
      e_fd  = '0;
      for (int k = sz - 1; k >= 0; k--) begin
        if (mq[k].filled && mq[k].addr == Ld_Addr) begin
          e_hit = 1;
          e_fd  = mq[k].data;
          break;
        end
      end
      chk("ld_fwd_hit", 32'(Ld_Fwd_Hit), 32'(e_hit));
      if (e_hit) chk("ld_fwd_data", 32'(Ld_Fwd_Data), 32'(e_fd));
      if (Mem_Wr_En && Mem_Ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_write: got unexpected %0h/%0h required none", Mem_Wr_Addr, Mem_Wr_Data);
        end else begin
          chk("mem_write", {Mem_Wr_Addr, Mem_Wr_Data}, exp_q.pop_front());
        end
      end
      // advance the model across the coming edge
      drn = e_en && Mem_Ready;
      for (int k = 0; k < mq.size(); k++) begin
        if (ROB_Retire1_SB_V && mq[k].idx == int'(ROB_Retire1_SB_Addr)) mq[k].committed = 1;
        if (ROB_Retire2_SB_V && mq[k].idx == int'(ROB_Retire2_SB_Addr)) mq[k].committed = 1;
        if (LSU_St_V && mq[k].idx == int'(LSU_St_Idx)) begin
          mq[k].filled = 1;
          mq[k].addr   = LSU_St_Addr;
          mq[k].data   = LSU_St_Data;
        end
      end
      if (drn) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (Flush) begin
        nq.delete();
        for (int k = 0; k < mq.size(); k++) if (mq[k].committed) nq.push_back(mq[k]);
        mq = nq;
      end else if (!stl) begin
        if (Alloc1_V) mq.push_back(mk(tl));
        if (Alloc2_V) mq.push_back(mk(e2));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr();
    Flush = 0; Alloc1_V = 0; Alloc2_V = 0;
    LSU_St_V = 0; LSU_St_Idx = '0; LSU_St_Addr = '0; LSU_St_Data = '0;
    ROB_Retire1_SB_V = 0; ROB_Retire1_SB_Addr = '0;
    ROB_Retire2_SB_V = 0; ROB_Retire2_SB_Addr = '0;
    Mem_Ready = 0; Ld_Addr = '0;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
    clr();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    RST = 1;
    clr();
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
  endtask

  task automatic fill(input int idx, input logic [15:0] a, input logic [15:0] d);
    LSU_St_V = 1; LSU_St_Idx = 5'(idx); LSU_St_Addr = a; LSU_St_Data = d;
  endtask

  task automatic retire1(input int idx);
    ROB_Retire1_SB_V = 1; ROB_Retire1_SB_Addr = 5'(idx);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_stall", 32'(SB_stall), 0);
    chk("rst_wr_en", 32'(Mem_Wr_En), 0);
    chk("rst_fwd_hit", 32'(Ld_Fwd_Hit), 0);
    chk("rst_idx1", 32'(Alloc_Idx1), 0);
    chk("rst_idx2", 32'(Alloc_Idx2), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    do_reset();
    settle(); chk_reset_outputs(); nxt();

    // dual allocation from reset
    Alloc1_V = 1; Alloc2_V = 1;
    settle(); chk("dual_idx1", 32'(Alloc_Idx1), 0); chk("dual_idx2", 32'(Alloc_Idx2), 1); nxt();
    settle(); chk("dual_next_idx1", 32'(Alloc_Idx1), 2); chk("dual_stall", 32'(SB_stall), 0); nxt();

    // alloc, fill, commit, drain
    do_reset();
    Alloc1_V = 1; nxt();
    fill(0, 16'h0040, 16'hBEEF); nxt();
    retire1(0); Mem_Ready = 1;
    settle(); chk("no_drain_on_commit", 32'(Mem_Wr_En), 0);
    exp_q.push_back({16'h0040, 16'hBEEF}); nxt();
    Mem_Ready = 1;
    settle(); chk("drain_en", 32'(Mem_Wr_En), 1);
    chk("drain_addr", 32'(Mem_Wr_Addr), 32'h0040); chk("drain_data", 32'(Mem_Wr_Data), 32'hBEEF); nxt();
    Alloc2_V = 1;
    settle(); chk("empty_wr_en", 32'(Mem_Wr_En), 0); chk("after_drain_idx1", 32'(Alloc_Idx1), 1);
    chk("slot2_only_idx2", 32'(Alloc_Idx2), 1); nxt();

    // forwarding picks youngest filled match, skips unfilled
    do_reset();
    repeat (3) begin Alloc1_V = 1; Alloc2_V = 1; nxt(); end
    fill(3, 16'h0010, 16'h1111); nxt();
    fill(5, 16'h0010, 16'h2222); nxt();
    fill(4, 16'h0020, 16'h4444); nxt();
    Ld_Addr = 16'h0010; settle();
    chk("fwd_hit_young", 32'(Ld_Fwd_Hit), 1); chk("fwd_data_young", 32'(Ld_Fwd_Data), 32'h2222); nxt();
    Ld_Addr = 16'h0020; settle(); chk("fwd_data_single", 32'(Ld_Fwd_Data), 32'h4444); nxt();
    Ld_Addr = 16'h0030; settle(); chk("fwd_miss", 32'(Ld_Fwd_Hit), 0); nxt();
    Ld_Addr = 16'h0000; settle(); chk("fwd_skip_unfilled", 32'(Ld_Fwd_Hit), 0); nxt();

    // stall near full, held requests, drain, wrap of allocation
    do_reset();
    repeat (15) begin Alloc1_V = 1; Alloc2_V = 1; nxt(); end
    settle(); chk("cnt30_idx1", 32'(Alloc_Idx1), 30); chk("cnt30_stall", 32'(SB_stall), 0); nxt();
    Alloc1_V = 1; nxt();
    repeat (3) begin
      Alloc1_V = 1; Alloc2_V = 1;
      settle(); chk("held_idx1", 32'(Alloc_Idx1), 31); chk("held_stall", 32'(SB_stall), 1); nxt();
    end
    Alloc1_V = 1; Alloc2_V = 1; fill(0, 16'h0100, 16'hA5A5); retire1(0); nxt();
    Alloc1_V = 1; Alloc2_V = 1; Mem_Ready = 1; exp_q.push_back({16'h0100, 16'hA5A5});
    settle(); chk("stall_drain_en", 32'(Mem_Wr_En), 1); chk("stall_during_drain", 32'(SB_stall), 1); nxt();
    Alloc1_V = 1; Alloc2_V = 1;
    settle(); chk("unstall", 32'(SB_stall), 0);
    chk("wrap_idx1", 32'(Alloc_Idx1), 31); chk("wrap_idx2", 32'(Alloc_Idx2), 0); nxt();
    settle(); chk("full_idx1", 32'(Alloc_Idx1), 1); chk("full_stall", 32'(SB_stall), 1); nxt();

    // flush with same-cycle commit and dropped allocation
    do_reset();
    repeat (2) begin Alloc1_V = 1; Alloc2_V = 1; nxt(); end
    retire1(0); ROB_Retire2_SB_V = 1; ROB_Retire2_SB_Addr = 5'd1;
    fill(3, 16'h0077, 16'h7777); nxt();
    Flush = 1; retire1(2); Alloc1_V = 1; Ld_Addr = 16'h0077;
    settle(); chk("pre_flush_hit", 32'(Ld_Fwd_Hit), 1); nxt();
    Ld_Addr = 16'h0077;
    settle(); chk("flushed_entry_gone", 32'(Ld_Fwd_Hit), 0); chk("flush_tail", 32'(Alloc_Idx1), 3);
    chk("flush_no_wr", 32'(Mem_Wr_En), 0); nxt();
    for (int i = 0; i < 3; i++) begin
      fill(i, 16'(16'h0200 + i), 16'(16'h1000 + i)); Mem_Ready = 1;
      exp_q.push_back({16'(16'h0200 + i), 16'(16'h1000 + i)}); nxt();
    end
    repeat (2) begin Mem_Ready = 1; nxt(); end
    settle(); chk("flush_drained_en", 32'(Mem_Wr_En), 0); chk("flush_drained_idx1", 32'(Alloc_Idx1), 3); nxt();

    // walk head to 31, back-pressure, then wrap to 0
    do_reset();
    for (int i = 0; i < 31; i++) begin
      Alloc1_V = 1; nxt();
      fill(i, 16'(16'h0300 + i), 16'(16'h5000 + i)); retire1(i); nxt();
      Mem_Ready = 1; exp_q.push_back({16'(16'h0300 + i), 16'(16'h5000 + i)}); nxt();
    end
    Alloc1_V = 1; Alloc2_V = 1;
    settle(); chk("h31_idx1", 32'(Alloc_Idx1), 31); chk("h31_idx2", 32'(Alloc_Idx2), 0); nxt();
    fill(31, 16'hABCD, 16'h1234); retire1(31); nxt();
    repeat (3) begin
      settle(); chk("bp_en", 32'(Mem_Wr_En), 1);
      chk("bp_addr", 32'(Mem_Wr_Addr), 32'hABCD); chk("bp_data", 32'(Mem_Wr_Data), 32'h1234); nxt();
    end
    Mem_Ready = 1; exp_q.push_back({16'hABCD, 16'h1234}); nxt();
    settle(); chk("wrap_head_en", 32'(Mem_Wr_En), 0); chk("wrap_tail", 32'(Alloc_Idx1), 1); nxt();
    fill(0, 16'h0ACE, 16'h0F0F); retire1(0); nxt();
    Mem_Ready = 1; exp_q.push_back({16'h0ACE, 16'h0F0F});
    settle(); chk("head0_en", 32'(Mem_Wr_En), 1); chk("head0_addr", 32'(Mem_Wr_Addr), 32'h0ACE); nxt();

    // reset abandons a pending write
    do_reset();
    Alloc1_V = 1; nxt();
    fill(0, 16'h0400, 16'h4444); retire1(0); nxt();
    settle(); chk("pending_en", 32'(Mem_Wr_En), 1); nxt();
    RST = 1; Mem_Ready = 1; nxt();
    nxt();
    RST = 0;
    settle(); chk_reset_outputs(); nxt();

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
